// File: rtl/reg_writeback.sv
//-----------------------------------------------------------------------------
// reg_writeback
//
// Writeback stage feeding the single write port of the 16x32 register file.
// Each cycle it picks one of two producers (ALU results and memory-load
// results), registers the winner onto write_addr/write_data, and keeps a
// scoreboard of registers that are waiting on an outstanding load.
//
// Arbitration: memory normally wins a conflict, but the ALU is guaranteed
// a win after STARVE_LIMIT consecutive losses. An ALU result whose
// destination has a load outstanding is held back (WAW guard) so the late
// load cannot overwrite a newer ALU value.
//
// Parameters:
//   STARVE_LIMIT  consecutive conflict losses before the ALU is forced to
//                 win one cycle (1..15)
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   alu_valid    ALU result available
//   alu_ready    ALU result accepted this cycle (with alu_valid)
//   alu_addr     ALU destination register
//   alu_data     ALU result value
//   mem_valid    load result available
//   mem_ready    load result accepted this cycle (with mem_valid)
//   mem_addr     load destination register
//   mem_data     load result value
//   issue_valid  load being issued to memory, marks destination pending
//   issue_ready  issue permitted (destination not already pending)
//   issue_addr   destination register of issuing load
//   pending      scoreboard, bit n set = load to rn outstanding, bit 0 is 0
//   write_addr   register file write address, 0 when idle
//   write_data   register file write data (holds when idle)
//
// Optional feature, macro WB_PRIV_CHECK_EN:
//   kernel_mode  input, privileged context
//   priv_fault   output, pulses for the slot of a suppressed write to r12..r15
//                made outside kernel mode
//-----------------------------------------------------------------------------
module reg_writeback #(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [3:0]  alu_addr,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_addr,
   input  logic [31:0] mem_data,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [3:0]  issue_addr,
   output logic [15:0] pending,
`ifdef WB_PRIV_CHECK_EN
   input  logic        kernel_mode,
   output logic        priv_fault,
`endif
   output logic [3:0]  write_addr,
   output logic [31:0] write_data
);

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   logic [3:0]  writeAddr_q, writeAddr_d;
   logic [31:0] writeData_q, writeData_d;
   logic [15:0] pending_q, pending_d;
   logic [3:0]  starveCnt_q, starveCnt_d;
`ifdef WB_PRIV_CHECK_EN
   logic        privFault_q, privFault_d;
   logic        privViolation;
`endif

   logic        aluOk;
   logic        memWins;
   logic        aluWins;
   logic        memFire;
   logic        aluFire;
   logic        anyFire;
   logic [3:0]  winAddr;
   logic [31:0] winData;

   // An ALU result may only compete when no load is still headed for the
   // same register; otherwise the load would later clobber the ALU value.
   // Memory takes a conflict unless the ALU has already lost STARVE_LIMIT
   // times in a row.
   always_comb begin
      aluOk   = alu_valid && !pending_q[alu_addr];
      memWins = mem_valid && !(aluOk && (starveCnt_q == StarveMax));
      aluWins = aluOk && !memWins;
   end

   // Handshakes are suppressed during reset so no producer thinks its
   // result was consumed while the stage is being cleared.
   always_comb begin
      mem_ready   = !rst && memWins;
      alu_ready   = !rst && aluWins;
      issue_ready = !rst && !pending_q[issue_addr];
      memFire     = mem_ready;
      aluFire     = alu_ready;
      anyFire     = memFire || aluFire;
      winAddr     = memFire ? mem_addr : alu_addr;
      winData     = memFire ? mem_data : alu_data;
   end

`ifdef WB_PRIV_CHECK_EN
   // Registers r12..r15 are reserved for kernel context; a user-mode write
   // there is consumed (so the producer does not stall) but never lands.
   always_comb begin
      privViolation = anyFire && (winAddr >= 4'd12) && !kernel_mode;
   end
`endif

   // Write port next state: a winner is presented for exactly one cycle,
   // otherwise the address drops to r0 (idle) and the data bus holds so it
   // does not toggle needlessly. A suppressed privileged write also leaves
   // the data bus alone so the value is not exposed.
   always_comb begin
      writeAddr_d = 4'd0;
      writeData_d = writeData_q;
`ifdef WB_PRIV_CHECK_EN
      privFault_d = privViolation;
      if (anyFire && !privViolation) begin
         writeAddr_d = winAddr;
         writeData_d = winData;
      end
`else
      if (anyFire) begin
         writeAddr_d = winAddr;
         writeData_d = winData;
      end
`endif
   end

   // Scoreboard next state: a retiring load clears its bit, then a new
   // issue sets its bit. Issue of a register that is already pending is
   // blocked by issue_ready, and r0 is never tracked because writes to it
   // are discarded anyway.
   always_comb begin
      pending_d = pending_q;
      if (memFire) begin
         pending_d[mem_addr] = 1'b0;
      end
      if (issue_valid && issue_ready && (issue_addr != 4'd0)) begin
         pending_d[issue_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Starvation counter: counts consecutive conflicts lost by the ALU and
   // saturates at the limit, which is what grants the ALU its forced win.
   // Any cycle without such a loss restarts the count.
   always_comb begin
      starveCnt_d = 4'd0;
      if (aluOk && mem_valid && memWins) begin
         starveCnt_d = (starveCnt_q == StarveMax) ? StarveMax
                                                  : starveCnt_q + 4'd1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         writeAddr_q <= 4'd0;
         writeData_q <= 32'd0;
         pending_q   <= 16'd0;
         starveCnt_q <= 4'd0;
`ifdef WB_PRIV_CHECK_EN
         privFault_q <= 1'b0;
`endif
      end else begin
         writeAddr_q <= writeAddr_d;
         writeData_q <= writeData_d;
         pending_q   <= pending_d;
         starveCnt_q <= starveCnt_d;
`ifdef WB_PRIV_CHECK_EN
         privFault_q <= privFault_d;
`endif
      end
   end

   assign write_addr = writeAddr_q;
   assign write_data = writeData_q;
   assign pending    = pending_q;
`ifdef WB_PRIV_CHECK_EN
   assign priv_fault = privFault_q;
`endif

endmodule
